divider64: RTL and testbench

Multi-cycle 64-bit integer divider: the inverse arithmetic path to the 64-bit carry-lookahead adder in the PersonalComputer datapath. It accepts a dividend/divisor pair on a start pulse and performs restoring division, one trial subtraction per cycle. It returns quotient, remainder and the standard flag set (SF/ZF/PF/OF) plus a divide-by-zero flag. It sits beside the ALU and is started by the control unit for DIV/MOD instructions; the control unit stalls on `busy`.

---
 rtl/divider64_pkg.sv | 15 +
 rtl/divider64_if.sv | 32 +++
 rtl/divider64_div_step.sv | 23 ++
 rtl/divider64.sv | 119 +++++++++++
 tb/tb_divider64.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/divider64_pkg.sv
// Shared types and sizing for the 64-bit restoring divider.
// Imported by the divider interface, datapath step and top level.
package div_pkg;

  localparam int DIV_WIDTH = 64;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/divider64_if.sv
// Request/result bundle between the control unit and divider64.
// The control unit is the master; the divider is the slave.
interface divider64_if;
  import div_pkg::*;

  logic                 start;
  logic                 sign;
  logic [DIV_WIDTH-1:0] A;
  logic [DIV_WIDTH-1:0] B;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;
  logic                 SF;
  logic                 ZF;
  logic                 PF;
  logic                 OF;
  logic                 DZ;

  modport master (
    output start, sign, A, B,
    input  busy, done, quotient, remainder,
    input  SF, ZF, PF, OF, DZ
  );

  modport slave (
    input  start, sign, A, B,
    output busy, done, quotient, remainder,
    output SF, ZF, PF, OF, DZ
  );

endinterface

// File: rtl/divider64_div_step.sv
// One restoring-division iteration: shift in a dividend bit and
// trial-subtract the divisor magnitude over 65 bits.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] r,
  input  logic [DIV_WIDTH-1:0] d,
  input  logic                 bit_in,
  output logic [DIV_WIDTH-1:0] r_next,
  output logic                 q_bit
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] trial;

  assign shifted = {r, bit_in};
  assign trial   = shifted - {1'b0, d};
  // Non-negative trial means the divisor fits.
  assign q_bit   = ~trial[DIV_WIDTH];
  assign r_next  = q_bit ? trial[DIV_WIDTH-1:0]
                         : shifted[DIV_WIDTH-1:0];

endmodule

// File: rtl/divider64.sv
// Multi-cycle 64-bit signed/unsigned restoring divider with
// quotient flags, overflow and divide-by-zero reporting.
module divider64
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic        clk,
  input  logic        rst,
  divider64_if.slave  bus
);

  div_state_t           state;
  logic [DIV_CNT_W-1:0] cnt;
  logic [WIDTH-1:0]     q_reg;
  logic [WIDTH-1:0]     r_reg;
  logic [WIDTH-1:0]     b_mag;
  logic                 q_neg;
  logic                 r_neg;
  logic                 of_pend;
  logic                 dz_pend;

  logic [WIDTH-1:0]     a_abs;
  logic [WIDTH-1:0]     b_abs;
  logic                 a_neg;
  logic                 b_neg;
  logic                 b_zero;
  logic                 min_by_m1;
  logic [WIDTH-1:0]     step_r;
  logic                 step_q;
  logic [WIDTH-1:0]     q_fin;
  logic [WIDTH-1:0]     r_fin;
  logic [WIDTH-1:0]     q_out;

  assign a_neg  = bus.sign & bus.A[WIDTH-1];
  assign b_neg  = bus.sign & bus.B[WIDTH-1];
  assign a_abs  = a_neg ? -bus.A : bus.A;
  assign b_abs  = b_neg ? -bus.B : bus.B;
  assign b_zero = (bus.B == '0);

  assign min_by_m1 = bus.sign
    && (bus.A == {1'b1, {(WIDTH-1){1'b0}}})
    && (bus.B == '1);

  div_step u_step (
    .r      (r_reg),
    .d      (b_mag),
    .bit_in (q_reg[WIDTH-1]),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  assign q_fin = q_neg ? -q_reg : q_reg;
  assign r_fin = r_neg ? -r_reg : r_reg;
  // Divide by zero returns all ones; q_reg holds raw A then.
  assign q_out = dz_pend ? '1 : q_fin;

  assign bus.busy = (state == DIV) || (state == FIX);
  assign bus.done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      q_reg         <= '0;
      r_reg         <= '0;
      b_mag         <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      of_pend       <= 1'b0;
      dz_pend       <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.SF        <= 1'b0;
      bus.ZF        <= 1'b0;
      bus.PF        <= 1'b0;
      bus.OF        <= 1'b0;
      bus.DZ        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            q_neg   <= bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            r_neg   <= a_neg;
            b_mag   <= b_abs;
            r_reg   <= '0;
            cnt     <= '1;
            of_pend <= min_by_m1;
            dz_pend <= b_zero;
            bus.OF  <= 1'b0;
            bus.DZ  <= 1'b0;
            q_reg   <= b_zero ? bus.A : a_abs;
            state   <= b_zero ? FIX : DIV;
          end else begin
            state   <= IDLE;
          end
        end
        DIV: begin
          r_reg <= step_r;
          q_reg <= {q_reg[WIDTH-2:0], step_q};
          cnt   <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          bus.quotient  <= q_out;
          bus.remainder <= dz_pend ? q_reg : r_fin;
          bus.SF        <= q_out[WIDTH-1];
          bus.ZF        <= (q_out == '0);
          bus.PF        <= ^q_out;
          bus.OF        <= of_pend & ~dz_pend;
          bus.DZ        <= dz_pend;
          state         <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider64.sv
// Directed self-checking bench for divider64.
// Vector table plus busy-ignore, back-to-back and reset sequences.
module tb_divider64;
  import div_pkg::*;

  typedef struct {
    logic        sgn;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic [4:0]  fl;
    int          lat;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  divider64_if bus ();

  divider64 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [4:0] flags();
    return {bus.SF, bus.ZF, bus.PF, bus.OF, bus.DZ};
  endfunction

  task automatic launch(input logic sgn,
                        input logic [63:0] a,
                        input logic [63:0] b);
    bus.sign  = sgn;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (!bus.done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic chk_res(input string nm,
                         input logic [63:0] q,
                         input logic [63:0] r,
                         input logic [4:0] fl,
                         input int exp_lat,
                         input int lat);
    chk({nm, " lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, " q"}, bus.quotient, q);
    chk({nm, " r"}, bus.remainder, r);
    chk({nm, " flags"}, {59'd0, flags()}, {59'd0, fl});
    chk({nm, " busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs [8];
  int   lat;

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    // flags order: SF ZF PF OF DZ
    vecs[0] = '{0, 64'd100, 64'd7, 64'd14, 64'd2, 5'b00100, 65};
    vecs[1] = '{1, -64'sd100, 64'd7,
                64'hFFFF_FFFF_FFFF_FFF2, -64'sd2, 5'b10100, 65};
    vecs[2] = '{1, 64'd100, -64'sd7,
                64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 5'b10100, 65};
    vecs[3] = '{0, 64'h1234, 64'd0, ONES, 64'h1234, 5'b10001, 1};
    vecs[4] = '{1, MIN, ONES, MIN, 64'd0, 5'b10110, 65};
    vecs[5] = '{0, MIN, ONES, 64'd0, MIN, 5'b01000, 65};
    vecs[6] = '{0, ONES, 64'h10,
                64'h0FFF_FFFF_FFFF_FFFF, 64'hF, 5'b00000, 65};
    vecs[7] = '{1, -64'sd7, -64'sd2, 64'd3, ONES, 5'b00000, 65};

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {63'd0, bus.busy}, 64'd0);
    chk("rst done", {63'd0, bus.done}, 64'd0);
    chk("rst q", bus.quotient, 64'd0);
    chk("rst r", bus.remainder, 64'd0);
    chk("rst flags", {59'd0, flags()}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      launch(vecs[i].sgn, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d busy", i), {63'd0, bus.busy}, 64'd1);
      wait_done(0, lat);
      chk_res($sformatf("v%0d", i), vecs[i].q, vecs[i].r,
              vecs[i].fl, vecs[i].lat, lat);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d done pulse", i),
          {63'd0, bus.done}, 64'd0);
    end

    // start while busy is dropped
    @(negedge clk);
    launch(1'b0, 64'd100, 64'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.sign  = 1'b0;
    bus.A     = 64'd1000;
    bus.B     = 64'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(10, lat);
    chk_res("ignore", 64'd14, 64'd2, 5'b00100, 65, lat);

    // accepted start in the done cycle
    launch(1'b0, 64'd1000, 64'd3);
    chk("b2b busy", {63'd0, bus.busy}, 64'd1);
    wait_done(0, lat);
    chk_res("b2b", 64'd333, 64'd1, 5'b00100, 65, lat);

    // async reset mid-DIV
    @(negedge clk);
    launch(1'b0, 64'd100, 64'd7);
    repeat (30) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("mid rst busy", {63'd0, bus.busy}, 64'd0);
    chk("mid rst done", {63'd0, bus.done}, 64'd0);
    chk("mid rst q", bus.quotient, 64'd0);
    chk("mid rst r", bus.remainder, 64'd0);
    chk("mid rst flags", {59'd0, flags()}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(1'b0, ONES, 64'h10);
    wait_done(0, lat);
    chk_res("post rst", 64'h0FFF_FFFF_FFFF_FFFF, 64'hF,
            5'b00000, 65, lat);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
